// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : dcache_ctrl_if
//  Purpose    : Bundles the Memory-stage request/response signals and the
//               main-memory port of the data cache into one interface.
//  Modports   : slave  - the cache controller (consumes requests and acks,
//                        drives load data, stall, memory request, counters)
//               master - the surrounding pipeline / memory (opposite view)
//  Signals    : req_valid/req_we/req_addr/req_wdata/req_funct3 - access
//               rdata/stall                 - load word, pipeline freeze
//               mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb  - memory request
//               mem_ack/mem_rdata           - memory completion
//               load_count/miss_count       - event counters
//  Revision   : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic [31:0] rdata;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] load_count;
   logic [31:0] miss_count;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
      output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             load_count, miss_count
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
      input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
             load_count, miss_count
   );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : dcache_ctrl
//  Purpose    : Direct-mapped, write-through, no-write-allocate data cache
//               and controller for the Memory stage. Freezes the pipeline
//               while a line refill or a store write-through is in flight.
//  Parameters : SETS       - number of lines (power of 2, >= 2)
//               LINE_WORDS - 32-bit words per line (power of 2, >= 2)
//  Ports      : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - dcache_ctrl_if.slave (request, load data, stall,
//                      main-memory port, load/miss counters)
//  Revision   : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic          clk,
   input  logic          rst,
   dcache_ctrl_if.slave  bus
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2,
      WDONE  = 2'd3
   } state_t;

   state_t            state, state_next;
   logic [OFF_W-1:0]  cnt;
   logic [SETS-1:0]   valid;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [31:0]       data_mem [SETS][LINE_WORDS];
   logic [31:0]       load_cnt, miss_cnt;

   logic [OFF_W-1:0]  offset;
   logic [IDX_W-1:0]  index;
   logic [TAG_W-1:0]  req_tag;
   logic              hit;
   logic [3:0]        st_strb;
   logic [31:0]       st_data;
   logic              fill_we, fill_last, merge_we, load_inc, miss_inc;
   logic              unused_funct3;

   assign offset  = bus.req_addr[OFF_W+1:2];
   assign index   = bus.req_addr[IDX_W+OFF_W+1:OFF_W+2];
   assign req_tag = bus.req_addr[31:IDX_W+OFF_W+2];
   assign hit     = valid[index] && (tag_mem[index] == req_tag);

   // Only funct3[1:0] encodes the store size.
   assign unused_funct3 = bus.req_funct3[2];

   assign bus.load_count = load_cnt;
   assign bus.miss_count = miss_cnt;

   // Store lane steering; the encoding 11 falls through to a full word.
   always_comb begin
      st_strb = 4'b1111;
      st_data = bus.req_wdata;
      case (bus.req_funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << bus.req_addr[1:0];
            st_data = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << {bus.req_addr[1], 1'b0};
            st_data = {2{bus.req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Next state and outputs. Memory-port outputs depend on the registered
   // state only, so an asynchronous reset drops mem_req immediately.
   always_comb begin
      state_next    = state;
      bus.stall     = 1'b0;
      bus.rdata     = 32'd0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'd0;
      bus.mem_wdata = 32'd0;
      bus.mem_wstrb = 4'b0000;
      fill_we       = 1'b0;
      fill_last     = 1'b0;
      merge_we      = 1'b0;
      load_inc      = 1'b0;
      miss_inc      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_we) begin
                  bus.stall  = 1'b1;
                  state_next = WRITE;
               end else if (hit) begin
                  bus.rdata = data_mem[index][offset];
                  load_inc  = 1'b1;
               end else begin
                  bus.stall  = 1'b1;
                  miss_inc   = 1'b1;
                  state_next = REFILL;
               end
            end
         end
         REFILL: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_addr = {req_tag, index, cnt, 2'b00};
            if (bus.mem_ack) begin
               fill_we = 1'b1;
               if (cnt == LAST_WORD) begin
                  fill_last  = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         WRITE: begin
            bus.stall     = 1'b1;
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = {bus.req_addr[31:2], 2'b00};
            bus.mem_wdata = st_data;
            bus.mem_wstrb = st_strb;
            if (bus.mem_ack) begin
               merge_we   = hit;
               state_next = WDONE;
            end
         end
         // One unstalled cycle lets the pipeline retire the store; the
         // still-held request is deliberately not looked at here.
         WDONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         valid    <= '0;
         load_cnt <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         state <= state_next;
         if (miss_inc)
            cnt <= '0;
         else if (fill_we)
            cnt <= cnt + OFF_W'(1);
         // Valid is set only with the last word, so an abandoned refill
         // leaves the line invalid.
         if (fill_last)
            valid[index] <= 1'b1;
         if (load_inc)
            load_cnt <= load_cnt + 32'd1;
         if (miss_inc)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end

   // Tag and data arrays carry no reset; validity alone guards them.
   always_ff @(posedge clk) begin
      if (fill_we)
         data_mem[index][cnt] <= bus.mem_rdata;
      if (fill_last)
         tag_mem[index] <= req_tag;
      if (merge_we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_strb[b])
               data_mem[index][offset][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_dcache_ctrl
//  Purpose    : Self-checking bench for dcache_ctrl (SETS=16, LINE_WORDS=4).
//               Expected memory transactions and load data are queued when a
//               request is driven and compared when the DUT produces them.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_ctrl_if dif();

   dcache_ctrl #(.SETS(16), .LINE_WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } mem_txn_t;

   mem_txn_t    exp_mem_q[$];
   logic [31:0] exp_rdata_q[$];
   logic [31:0] mem_model [logic [31:0]];
   bit          tb_valid [16];
   logic [23:0] tb_tag   [16];
   int          tests = 0;
   int          errors = 0;
   int          ack_count = 0;
   logic [31:0] exp_load = 32'd0;
   logic [31:0] exp_miss = 32'd0;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [3:0] s,
                                       input logic [31:0] d);
      logic [31:0] w;
      w = model_read(a);
      for (int b = 0; b < 4; b++)
         if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mem_model[a] = w;
   endfunction

   // Main-memory responder: acks every cycle mem_req is high and checks
   // each request against the next queued expectation.
   initial begin
      mem_txn_t it;
      dif.mem_ack   = 1'b0;
      dif.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (dif.mem_req === 1'b1) begin
            tests++;
            if (exp_mem_q.size() == 0) begin
               errors++;
               $display("FAIL mem_unexpected: got addr=%h we=%b, required no request",
                        dif.mem_addr, dif.mem_we);
            end else begin
               it = exp_mem_q.pop_front();
               if (it.we) begin
                  if ({dif.mem_we, dif.mem_addr, dif.mem_wstrb, dif.mem_wdata} !==
                      {1'b1, it.addr, it.strb, it.data}) begin
                     errors++;
                     $display("FAIL mem_write: got we=%b addr=%h strb=%b data=%h, required we=1 addr=%h strb=%b data=%h",
                              dif.mem_we, dif.mem_addr, dif.mem_wstrb, dif.mem_wdata,
                              it.addr, it.strb, it.data);
                  end
                  model_write(it.addr, it.strb, it.data);
               end else begin
                  if ({dif.mem_we, dif.mem_addr} !== {1'b0, it.addr}) begin
                     errors++;
                     $display("FAIL mem_read: got we=%b addr=%h, required we=0 addr=%h",
                              dif.mem_we, dif.mem_addr, it.addr);
                  end
                  dif.mem_rdata = model_read(it.addr);
               end
            end
            dif.mem_ack = 1'b1;
            ack_count++;
         end else begin
            dif.mem_ack = 1'b0;
         end
      end
   end

   // Issues a load at posedge+1 and returns at the next posedge+1.
   task automatic do_load(input logic [31:0] addr, input string name, output logic [31:0] got);
      logic [3:0]  idx;
      logic [23:0] tg;
      bit          hit;
      int          stalls;
      logic [31:0] exp_d;
      idx = addr[7:4];
      tg  = addr[31:8];
      hit = tb_valid[idx] && (tb_tag[idx] == tg);
      if (!hit) begin
         for (int w = 0; w < 4; w++)
            exp_mem_q.push_back('{1'b0, {tg, idx, 2'(w), 2'b00}, 4'b0000, 32'd0});
         exp_miss++;
         tb_valid[idx] = 1'b1;
         tb_tag[idx]   = tg;
      end
      exp_rdata_q.push_back(model_read({addr[31:2], 2'b00}));
      dif.req_valid  = 1'b1;
      dif.req_we     = 1'b0;
      dif.req_addr   = addr;
      dif.req_wdata  = 32'd0;
      dif.req_funct3 = 3'b010;
      @(negedge clk);
      tests++;
      if (dif.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_mem_req_detect: got %b, required 0", name, dif.mem_req);
      end
      stalls = 0;
      while (dif.stall === 1'b1 && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      tests++;
      if (stalls != (hit ? 0 : 5)) begin
         errors++;
         $display("FAIL %s_stall_cycles: got %0d, required %0d", name, stalls, hit ? 0 : 5);
      end
      got   = dif.rdata;
      exp_d = exp_rdata_q.pop_front();
      tests++;
      if (got !== exp_d) begin
         errors++;
         $display("FAIL %s_rdata: got %h, required %h", name, got, exp_d);
      end
      @(posedge clk);
      #1;
      dif.req_valid = 1'b0;
      exp_load++;
      tests++;
      if ({dif.load_count, dif.miss_count} !== {exp_load, exp_miss}) begin
         errors++;
         $display("FAIL %s_counters: got load=%0d miss=%0d, required load=%0d miss=%0d",
                  name, dif.load_count, dif.miss_count, exp_load, exp_miss);
      end
   endtask

   // Issues a store; expected memory write given explicitly by the caller.
   task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_data,
                           input string name);
      int stalls;
      exp_mem_q.push_back('{1'b1, exp_addr, exp_strb, exp_data});
      dif.req_valid  = 1'b1;
      dif.req_we     = 1'b1;
      dif.req_addr   = addr;
      dif.req_wdata  = wdata;
      dif.req_funct3 = f3;
      @(negedge clk);
      stalls = 0;
      while (dif.stall === 1'b1 && stalls < 20) begin
         stalls++;
         @(negedge clk);
      end
      tests++;
      if (stalls != 2) begin
         errors++;
         $display("FAIL %s_stall_cycles: got %0d, required 2", name, stalls);
      end
      tests++;
      if (dif.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL %s_wdone_mem_req: got %b, required 0", name, dif.mem_req);
      end
      @(posedge clk);
      #1;
      dif.req_valid = 1'b0;
      dif.req_we    = 1'b0;
      tests++;
      if ({dif.load_count, dif.miss_count} !== {exp_load, exp_miss}) begin
         errors++;
         $display("FAIL %s_counters: got load=%0d miss=%0d, required load=%0d miss=%0d",
                  name, dif.load_count, dif.miss_count, exp_load, exp_miss);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) tb_valid[i] = 1'b0;
      exp_load = 32'd0;
      exp_miss = 32'd0;
      exp_mem_q.delete();
      exp_rdata_q.delete();
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      dif.req_valid  = 1'b0;
      dif.req_we     = 1'b0;
      dif.req_addr   = 32'd0;
      dif.req_wdata  = 32'd0;
      dif.req_funct3 = 3'b010;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      dif.req_valid = 1'b1;
      dif.req_addr  = 32'h100;
      #1;
      tests++;
      if (dif.stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_stall_req: got %b, required 1", dif.stall);
      end
      tests++;
      if ({dif.mem_req, dif.mem_we, dif.mem_addr, dif.mem_wdata, dif.mem_wstrb} !== 70'd0) begin
         errors++;
         $display("FAIL reset_mem_port: got req=%b we=%b addr=%h data=%h strb=%b, required all 0",
                  dif.mem_req, dif.mem_we, dif.mem_addr, dif.mem_wdata, dif.mem_wstrb);
      end
      tests++;
      if ({dif.rdata, dif.load_count, dif.miss_count} !== 96'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdata=%h load=%0d miss=%0d, required 0 0 0",
                  dif.rdata, dif.load_count, dif.miss_count);
      end
      dif.req_valid = 1'b0;
      #1;
      tests++;
      if (dif.stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall_idle: got %b, required 0", dif.stall);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_miss_and_hit();
      logic [31:0] got;
      do_load(32'h100, "miss_0x100", got);
      do_load(32'h108, "hit_0x108", got);
   endtask

   task automatic test_store_byte_hit();
      logic [31:0] got;
      do_store(32'h101, 32'h0000_00AB, 3'b000, 32'h100, 4'b0010, 32'hABAB_ABAB, "sb_0x101");
      do_load(32'h100, "hit_after_sb", got);
      tests++;
      if (got[15:8] !== 8'hAB) begin
         errors++;
         $display("FAIL sb_merged_byte1: got %h, required ab", got[15:8]);
      end
   endtask

   task automatic test_conflict();
      logic [31:0] got;
      do_load(32'h500, "miss_0x500", got);
      do_load(32'h100, "remiss_0x100", got);
   endtask

   task automatic test_store_miss();
      logic [31:0] got;
      do_store(32'h200, 32'h1234_5678, 3'b010, 32'h200, 4'b1111, 32'h1234_5678, "sw_0x200");
      do_load(32'h200, "miss_after_sw", got);
   endtask

   task automatic test_store_sizes();
      logic [31:0] got;
      do_store(32'h10E, 32'h0000_BEEF, 3'b001, 32'h10C, 4'b1100, 32'hBEEF_BEEF, "sh_0x10e");
      do_store(32'h104, 32'hCAFE_F00D, 3'b011, 32'h104, 4'b1111, 32'hCAFE_F00D, "f3_11_0x104");
      do_store(32'h10A, 32'h1122_3344, 3'b010, 32'h108, 4'b1111, 32'h1122_3344, "sw_misalign");
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      do_load(32'h10C, "b2b_0x10c", got);
      do_load(32'h104, "b2b_0x104", got);
      do_load(32'h108, "b2b_0x108", got);
   endtask

   task automatic test_reset_mid_refill();
      logic [31:0] got;
      int base, n;
      do_load(32'h500, "evict_0x100", got);
      for (int w = 0; w < 4; w++)
         exp_mem_q.push_back('{1'b0, 32'h100 + 32'(4*w), 4'b0000, 32'd0});
      dif.req_valid = 1'b1;
      dif.req_we    = 1'b0;
      dif.req_addr  = 32'h100;
      base = ack_count;
      n    = 0;
      while (ack_count < base + 2 && n < 20) begin
         @(posedge clk);
         n++;
      end
      tests++;
      if (ack_count != base + 2) begin
         errors++;
         $display("FAIL rst_refill_acks: got %0d, required 2", ack_count - base);
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (dif.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_refill_mem_req: got %b, required 0", dif.mem_req);
      end
      dif.req_valid = 1'b0;
      clear_model();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (dif.miss_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_refill_miss_count: got %0d, required 0", dif.miss_count);
      end
      do_load(32'h100, "refill_after_rst", got);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_miss_and_hit();
      test_store_byte_hit();
      test_conflict();
      test_store_miss();
      test_store_sizes();
      test_back_to_back();
      test_reset_mid_refill();
      repeat (2) @(posedge clk);
      tests++;
      if (exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL mem_queue_drained: got %0d pending, required 0", exp_mem_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
`default_nettype wire
